// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Purpose  : Two-requester arbiter for a single word-wide synchronous-read
//            memory port. One transaction is in flight at a time. Each one
//            runs a fixed IDLE -> ACCESS -> WAIT sequence and is checked
//            against the memory's region capability flags before the write
//            strobe is allowed.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   FIRST_PORT    : port (0/1) that wins a simultaneous request on the
//                   first arbitration after reset
// Ports
//   clk           : in  system clock, rising edge
//   rst           : in  asynchronous active-low reset
//   pN_req        : in  port N request, held high until pN_ack
//   pN_we         : in  port N write (1) / read (0)
//   pN_address    : in  port N word address [31:2]
//   pN_wdata      : in  port N write data
//   pN_rdata      : out port N read data, valid with pN_ack, held afterwards
//   pN_ack        : out port N one-cycle completion pulse
//   pN_fault      : out port N capability fault, valid with pN_ack
//   address       : out memory word address [31:2]
//   memory_in     : out memory write data
//   write_enable  : out memory write strobe
//   memory_out    : in  memory read data, one cycle after address
//   read_capable  : in  current address is readable
//   write_capable : in  current address is writable
//   busy          : out high whenever not IDLE
// ============================================================================
module mem_arbiter #(
  parameter int unsigned FIRST_PORT = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        p0_req,
  input  logic        p0_we,
  input  logic [31:2] p0_address,
  input  logic [31:0] p0_wdata,
  output logic [31:0] p0_rdata,
  output logic        p0_ack,
  output logic        p0_fault,
  input  logic        p1_req,
  input  logic        p1_we,
  input  logic [31:2] p1_address,
  input  logic [31:0] p1_wdata,
  output logic [31:0] p1_rdata,
  output logic        p1_ack,
  output logic        p1_fault,
  output logic [31:2] address,
  output logic [31:0] memory_in,
  output logic        write_enable,
  input  logic [31:0] memory_out,
  input  logic        read_capable,
  input  logic        write_capable,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2
  } state_t;

  // Reset value of the round-robin pointer: "last granted" is the other
  // port, so FIRST_PORT wins the first tie.
  localparam logic LAST_RST = (FIRST_PORT == 0) ? 1'b1 : 1'b0;

  state_t      state_q, state_d;
  logic        port_q, port_d;
  logic        we_q, we_d;
  logic [31:2] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        last_q, last_d;
  logic        fault_q, fault_d;
  logic        ack0_q, ack0_d;
  logic        ack1_q, ack1_d;
  logic        flt0_q, flt0_d;
  logic        flt1_q, flt1_d;
  logic [31:0] rdata0_q, rdata0_d;
  logic [31:0] rdata1_q, rdata1_d;

  logic        elig0, elig1;
  logic        grant;
  logic        access_fault;
  logic [31:0] capture;

  // A port is not eligible in its own ack cycle: its req is still high
  // there because the requester only sees the ack in that same cycle.
  assign elig0 = p0_req & ~ack0_q;
  assign elig1 = p1_req & ~ack1_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      port_q   <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      last_q   <= LAST_RST;
      fault_q  <= 1'b0;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      flt0_q   <= 1'b0;
      flt1_q   <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q  <= state_d;
      port_q   <= port_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      last_q   <= last_d;
      fault_q  <= fault_d;
      ack0_q   <= ack0_d;
      ack1_q   <= ack1_d;
      flt0_q   <= flt0_d;
      flt1_q   <= flt1_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    port_d       = port_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    last_d       = last_q;
    fault_d      = fault_q;
    ack0_d       = 1'b0;
    ack1_d       = 1'b0;
    flt0_d       = 1'b0;
    flt1_d       = 1'b0;
    rdata0_d     = rdata0_q;
    rdata1_d     = rdata1_q;
    address      = '0;
    memory_in    = '0;
    write_enable = 1'b0;
    grant        = 1'b0;
    access_fault = 1'b0;
    capture      = '0;

    case (state_q)
      IDLE: begin
        if (elig0 | elig1) begin
          // On a tie the port not granted last wins.
          grant   = (elig0 & elig1) ? ~last_q : elig1;
          port_d  = grant;
          last_d  = grant;
          we_d    = grant ? p1_we      : p0_we;
          addr_d  = grant ? p1_address : p0_address;
          wdata_d = grant ? p1_wdata   : p0_wdata;
          state_d = ACCESS;
        end
      end

      ACCESS: begin
        address      = addr_q;
        memory_in    = wdata_q;
        access_fault = we_q ? ~write_capable : ~read_capable;
        // The strobe is combinational so an asynchronous reset in this
        // cycle removes it before the committing edge.
        write_enable = we_q & ~access_fault;
        fault_d      = access_fault;
        state_d      = WAIT;
      end

      WAIT: begin
        // Address stays on the bus so the synchronous-read data presented
        // this cycle belongs to the granted transaction.
        address   = addr_q;
        memory_in = wdata_q;
        capture   = (!we_q && !fault_q) ? memory_out : 32'd0;
        if (port_q) begin
          rdata1_d = capture;
          ack1_d   = 1'b1;
          flt1_d   = fault_q;
        end else begin
          rdata0_d = capture;
          ack0_d   = 1'b1;
          flt0_d   = fault_q;
        end
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign p0_rdata = rdata0_q;
  assign p0_ack   = ack0_q;
  assign p0_fault = flt0_q;
  assign p1_rdata = rdata1_q;
  assign p1_ack   = ack1_q;
  assign p1_fault = flt1_q;
  assign busy     = (state_q != IDLE);

endmodule
`default_nettype wire
